// File: rtl/npc_pkg.sv
// ============================================================================
// Module  : npc_pkg
// Brief   : Shared constants and fetch FSM encoding for the NPC core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

   localparam int unsigned          NPC_ADDR_WIDTH = 32;
   localparam int unsigned          NPC_INST_WIDTH = 32;
   localparam logic [31:0]          NPC_RESET_PC   = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module  : ifu_fetch
// Brief   : Single-outstanding instruction fetch with redirect and decode handoff.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
   import npc_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = NPC_ADDR_WIDTH,
   parameter int unsigned            INST_WIDTH = NPC_INST_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(NPC_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  rsp_valid,
   input  logic [INST_WIDTH-1:0] rsp_inst,
   input  logic                  rsp_err,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic                  out_fault,
   output logic [31:0]           fetch_count
);

   localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  discard_q, discard_d;
   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
   logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
   logic                  out_fault_q, out_fault_d;
   logic [31:0]           fetch_count_q, fetch_count_d;
   logic                  w_req_fire;

   // Request is suppressed for the whole reset cycle, not only after the edge.
   assign req_valid   = rst_n && (state_q == S_REQ);
   assign req_addr    = pc_q;
   assign w_req_fire  = req_valid && req_ready;

   assign out_valid   = out_valid_q;
   assign out_pc      = out_pc_q;
   assign out_inst    = out_inst_q;
   assign out_fault   = out_fault_q;
   assign fetch_count = fetch_count_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      discard_d     = discard_q;
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_inst_d    = out_inst_q;
      out_fault_d   = out_fault_q;
      fetch_count_d = fetch_count_q;

      unique case (state_q)
         S_REQ: begin
            if (w_req_fire) begin
               state_d = S_WAIT;
               if (redirect_valid) discard_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (rsp_valid) begin
               if (discard_q || redirect_valid) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  out_pc_d    = pc_q;
                  out_inst_d  = rsp_inst;
                  out_fault_d = rsp_err;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + c_pc_step;
                  state_d     = S_HOLD;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) fetch_count_d = fetch_count_q + 32'd1;
            if (out_ready || redirect_valid) begin
               out_valid_d = 1'b0;
               state_d     = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // Redirect wins over any sequential PC update in every state.
      if (redirect_valid) pc_d = redirect_pc & c_align_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         discard_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_inst_q    <= '0;
         out_fault_q   <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         discard_q     <= discard_d;
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_inst_q    <= out_inst_d;
         out_fault_q   <= out_fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module  : tb_ifu_fetch
// Brief   : Directed scoreboard bench for ifu_fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_inst;
   logic        rsp_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_inst;
   logic        out_fault;
   logic [31:0] fetch_count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } out_t;

   out_t        exp_out[$];
   logic [31:0] exp_req[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .rsp_valid      (rsp_valid),
      .rsp_inst       (rsp_inst),
      .rsp_err        (rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_fault      (out_fault),
      .fetch_count    (fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
   endtask

   task automatic do_rsp(input logic [31:0] inst, input logic err);
      rsp_valid = 1'b1;
      rsp_inst  = inst;
      rsp_err   = err;
      tick();
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
   endtask

   task automatic do_take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic push_out(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
      out_t e;
      e.pc = pc; e.inst = inst; e.fault = fault;
      exp_out.push_back(e);
   endtask

   // Request monitor: every accepted request must match the next expected address.
   initial begin
      forever begin
         @(negedge clk);
         if (req_valid && req_ready) begin
            if (exp_req.size() == 0) check("unexpected_req", req_addr, 32'hFFFF_FFFF);
            else check("req_addr", req_addr, exp_req.pop_front());
         end
      end
   end

   // Output monitor: compare on first presentation, then hold-stability while valid.
   initial begin
      out_t cur;
      bit   seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !seen) begin
            if (exp_out.size() == 0) begin
               check("unexpected_out", {31'd0, out_valid}, 32'd0);
               cur.pc = out_pc; cur.inst = out_inst; cur.fault = out_fault;
            end else begin
               cur = exp_out.pop_front();
               check("out_pc", out_pc, cur.pc);
               check("out_inst", out_inst, cur.inst);
               check("out_fault", {31'd0, out_fault}, {31'd0, cur.fault});
            end
         end else if (out_valid && seen) begin
            check("hold_pc", out_pc, cur.pc);
            check("hold_inst", out_inst, cur.inst);
         end
         seen = out_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0; rsp_err = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_req_valid", {31'd0, req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_fault", {31'd0, out_fault}, 32'd0);
      check("rst_count", fetch_count, 32'd0);
      rst_n = 1'b1;

      // Zero-latency loop, two instructions.
      for (int i = 0; i < 2; i++) begin
         exp_req.push_back(32'h8000_0000 + 32'(i * 4));
         push_out(32'h8000_0000 + 32'(i * 4), 32'h0010_0093, 1'b0);
         do_req(); do_rsp(32'h0010_0093, 1'b0); do_take();
      end
      check("loop_count", fetch_count, 32'd2);
      check("loop_next_addr", req_addr, 32'h8000_0008);

      // Memory stall: request held stable.
      for (int i = 0; i < 5; i++) begin
         check("stall_req_valid", {31'd0, req_valid}, 32'd1);
         check("stall_req_addr", req_addr, 32'h8000_0008);
         check("stall_out_valid", {31'd0, out_valid}, 32'd0);
         tick();
      end

      // Decode backpressure.
      exp_req.push_back(32'h8000_0008);
      push_out(32'h8000_0008, 32'h0020_8113, 1'b0);
      do_req(); do_rsp(32'h0020_8113, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("bp_req_valid", {31'd0, req_valid}, 32'd0);
         check("bp_count", fetch_count, 32'd2);
         tick();
      end
      do_take();
      check("bp_count_after", fetch_count, 32'd3);
      check("bp_req_valid_after", {31'd0, req_valid}, 32'd1);
      check("bp_next_addr", req_addr, 32'h8000_000C);

      // Redirect in WAIT; response two cycles later is dropped.
      exp_req.push_back(32'h8000_000C);
      do_req();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
      tick();
      redirect_valid = 1'b0;
      tick();
      do_rsp(32'hDEAD_BEEF, 1'b0);
      check("rw_out_valid", {31'd0, out_valid}, 32'd0);
      check("rw_next_addr", req_addr, 32'h8000_0100);
      check("rw_count", fetch_count, 32'd3);

      // Redirect with the request handshake, then a second redirect while discarding.
      exp_req.push_back(32'h8000_0100);
      req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      tick();
      req_ready = 1'b0; redirect_pc = 32'h8000_0204;
      tick();
      redirect_valid = 1'b0;
      do_rsp(32'h1111_1111, 1'b0);
      check("rh_out_valid", {31'd0, out_valid}, 32'd0);
      check("rh_next_addr", req_addr, 32'h8000_0204);

      // Redirect in HOLD without decode accepting.
      exp_req.push_back(32'h8000_0204);
      push_out(32'h8000_0204, 32'h2222_2222, 1'b0);
      do_req(); do_rsp(32'h2222_2222, 1'b0);
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
      tick();
      redirect_valid = 1'b0;
      check("rhold_out_valid", {31'd0, out_valid}, 32'd0);
      check("rhold_req_valid", {31'd0, req_valid}, 32'd1);
      check("rhold_next_addr", req_addr, 32'h8000_0300);
      check("rhold_count", fetch_count, 32'd3);

      // Fault at the top of the address space, PC wraps to zero.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      check("wrap_req_addr", req_addr, 32'hFFFF_FFFC);
      exp_req.push_back(32'hFFFF_FFFC);
      push_out(32'hFFFF_FFFC, 32'h0000_0073, 1'b1);
      do_req(); do_rsp(32'h0000_0073, 1'b1);
      check("wrap_fault", {31'd0, out_fault}, 32'd1);
      check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      do_take();
      check("wrap_next_addr", req_addr, 32'h0000_0000);
      check("wrap_count", fetch_count, 32'd4);

      // Redirect in HOLD while decode accepts: counted.
      exp_req.push_back(32'h0000_0000);
      push_out(32'h0000_0000, 32'h0000_0013, 1'b0);
      do_req(); do_rsp(32'h0000_0013, 1'b0);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      out_ready = 1'b0; redirect_valid = 1'b0;
      check("rtake_count", fetch_count, 32'd5);
      check("rtake_next_addr", req_addr, 32'h0000_0040);

      // Reset mid-transaction; a late response in REQ is ignored.
      exp_req.push_back(32'h0000_0040);
      do_req();
      rst_n = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h3333_3333;
      check("mrst_req_valid_wait", {31'd0, req_valid}, 32'd0);
      tick();
      check("mrst_req_valid_req", {31'd0, req_valid}, 32'd0);
      rst_n = 1'b1;
      tick();
      rsp_valid = 1'b0;
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_req_valid", {31'd0, req_valid}, 32'd1);
      check("mrst_req_addr", req_addr, 32'h8000_0000);
      check("mrst_count", fetch_count, 32'd0);

      tick();
      check("req_queue_drained", exp_req.size(), 32'd0);
      check("out_queue_drained", exp_out.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the NPC core. It is the requesting end of the instruction-memory interface: it owns the PC, issues one fetch request at a time, receives the 32-bit instruction word, and hands a (pc, inst) pair to decode over a valid/ready handshake. Branch and jump redirects from execute are honoured with in-flight responses discarded.

Parameters:
ADDR_WIDTH, 32, PC/address width
INST_WIDTH, 32, instruction word width
RESET_PC, 32'h8000_0000, PC loaded on reset (start of the instruction region)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_addr  out  ADDR_WIDTH  fetch address (word aligned)
rsp_valid  in  1  instruction word returned for the outstanding request
rsp_inst  in  INST_WIDTH  returned instruction word
rsp_err  in  1  access fault for the returned word
redirect_valid  in  1  redirect PC this cycle
redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0)
out_valid  out  1  fetched instruction valid to decode
out_ready  in  1  decode accepts
out_pc  out  ADDR_WIDTH  PC of out_inst
out_inst  out  INST_WIDTH  instruction word
out_fault  out  1  rsp_err captured with the word
fetch_count  out  32  count of out handshakes, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at edge): state=REQ, pc=RESET_PC, discard=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0, fetch_count=0. req_valid is 0 during any cycle rst_n=0. Reset mid-transaction abandons it; a late rsp_valid arriving in state REQ is ignored.
- FSM states REQ, WAIT, HOLD:
  - REQ: req_valid=1, req_addr=pc. req_valid and req_addr are held stable until req_ready. On req_valid&&req_ready -> WAIT.
  - WAIT: req_valid=0. On rsp_valid: if discard=1 or redirect_valid=1, drop the word, clear discard -> REQ. Otherwise capture out_pc=pc, out_inst=rsp_inst, out_fault=rsp_err, out_valid=1, pc=pc+4 -> HOLD.
  - HOLD: out_* stable while out_valid&&!out_ready. On out_ready: out_valid=0, fetch_count+1 -> REQ.
- Exactly one outstanding request; rsp_valid outside WAIT is ignored.
- Minimum loop: REQ accept (cycle 0) -> rsp (cycle 1) -> out_valid (cycle 2) -> handshake (cycle 2) -> next req_valid (cycle 3). Throughput is one instruction per 3 cycles at zero memory latency.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0.
- Redirect has priority over pc+4 in every state; pc=redirect_pc&~3 at the next edge:
  - REQ, no handshake: the next request uses the new pc.
  - REQ with handshake in the same cycle: go to WAIT with discard=1.
  - WAIT: set discard=1, or drop immediately if rsp_valid is in the same cycle.
  - HOLD: out_valid=0 and go to REQ. fetch_count increments only if out_ready is also high, because decode consumed the word.
- A second redirect while discard=1 only updates pc.
- out_fault does not stall; decode handles it.

Decomposition:
- Shared package npc_pkg: RESET_PC constant, INST_WIDTH, fetch state enum (REQ/WAIT/HOLD).
- Single module. No sub-module is needed; the FSM, PC register and output register are tightly coupled.

Test Plan:
- Reset then zero-latency memory returning 0x00100093 with out_ready=1 -> req_addr=0x8000_0000, then 0x8000_0004; out_pc 0x8000_0000 then 0x8000_0004; fetch_count=2 after 6 cycles.
- req_ready held 0 for 5 cycles -> req_valid=1 and req_addr=0x8000_0000 stable throughout; no out_valid.
- Decode backpressure: out_ready=0 for 4 cycles in HOLD -> out_pc/out_inst unchanged, req_valid=0, fetch_count unchanged; then out_ready=1 -> count+1, req next cycle.
- Redirect to 0x8000_0103 during WAIT, response arrives 2 cycles later -> response dropped, out_valid never asserted, next req_addr=0x8000_0100.
- Redirect in the same cycle as the REQ handshake, and redirect in HOLD with out_ready=0 -> stale word discarded; next req_addr=redirect target; fetch_count unchanged.
- rsp_err=1 with redirect to pc 0xFFFF_FFFC -> out_fault=1 with out_pc=0xFFFF_FFFC; next req_addr=0x0000_0000 (wrap).
